seg7_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed 4-digit seven-segment bus driven by the display controller. It watches the active-low anode and cathode lines and rebuilds the four displayed hex digits and decimal points. Once all four digits have been captured, it presents them as one frame. It sits beside the display driver in self-checking benches and on-chip loopback tests.

---
 rtl/seg7_pkg.sv | 69 ++++++
 rtl/seg7_settle_filter.sv | 60 ++++++
 rtl/seg7_scan_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types, constants and helpers for the seven-segment
//                scan-bus monitor: bus layout, glyph table, anode counting
//                and glyph decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Number of multiplexed digits on the bus.
    localparam int c_ANODE_COUNT = 4;

    // Number of segment cathodes (a..g).
    localparam int c_SEG_COUNT = 7;

    // One sample of the bus, all lines in their native active-low form.
    // seg_n[0] is segment a, seg_n[6] is segment g; an_n[0] is the
    // rightmost digit.
    typedef struct packed {
        logic [c_ANODE_COUNT-1:0] an_n;
        logic [c_SEG_COUNT-1:0]   seg_n;
        logic                     dp_n;
    } seg7_bus_t;

    // Idle bus: every anode off, every segment off, decimal point off.
    localparam seg7_bus_t c_BUS_IDLE = '{an_n: 4'hF, seg_n: 7'h7F, dp_n: 1'b1};

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic       err;
        logic [3:0] nibble;
    } glyph_t;

    // Active-high gfedcba patterns for hex digits 0..F; entry i is digit i.
    localparam logic [15:0][6:0] c_GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Count how many anodes are driven low (active) in one sample.
    function automatic logic [2:0] f_active_anodes(input logic [c_ANODE_COUNT-1:0] an_n);
        logic [2:0] count;
        count = 3'd0;
        for (int i = 0; i < c_ANODE_COUNT; i++) begin
            count = count + {2'b00, ~an_n[i]};
        end
        return count;
    endfunction

    // Map an active-high gfedcba pattern to its hex value. Patterns that
    // are not in the table decode to nibble 0 with the error flag set.
    function automatic glyph_t f_glyph_decode(input logic [c_SEG_COUNT-1:0] pattern);
        glyph_t result;
        result = '{err: 1'b1, nibble: 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (pattern == c_GLYPH_TABLE[i]) begin
                result = '{err: 1'b0, nibble: 4'(i)};
            end
        end
        return result;
    endfunction

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_settle_filter.sv
// ============================================================================
//  Module      : seg7_settle_filter
//  Description : Tracks how long the bus sample has been unchanged and raises
//                a one-cycle capture strobe when a single-anode sample has
//                been stable for SETTLE_CYCLES consecutive samples. The strobe
//                fires once per stable period and is valid in the same cycle
//                as the sample it refers to.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_settle_filter
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  seg7_bus_t i_sample,
    output logic      o_capture
);

    localparam logic [7:0] c_SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] c_SETTLE_HIT = 8'(SETTLE_CYCLES - 1);

    seg7_bus_t  r_prev;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_single_anode;

    // Next settle count: restart on any change, otherwise count up and hold
    // at the saturation value so the hit value is passed only once.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_sample != r_prev) begin
            w_cnt_next = 8'd0;
        end else if (r_cnt != c_SETTLE_MAX) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // Previous-sample register and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= c_BUS_IDLE;
            r_cnt  <= 8'd0;
        end else begin
            r_prev <= i_sample;
            r_cnt  <= w_cnt_next;
        end
    end

    assign w_single_anode = (f_active_anodes(i_sample.an_n) == 3'd1);

    // Blanked or conflicting samples never produce a strobe.
    assign o_capture = (w_cnt_next == c_SETTLE_HIT) && w_single_anode;

endmodule : seg7_settle_filter

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Receive-side monitor for a multiplexed 4-digit seven-segment
//                bus. Rebuilds the displayed hex digits and decimal points
//                from the active-low anode/cathode lines and publishes them
//                as a frame once all four digits have been captured. Flags
//                anode conflicts and scan stalls.
//  Options     : SEG7_SCAN_DECODER_SYNC_EN - when defined, a two-flop
//                synchroniser is placed on all bus inputs (+2 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset,
    input  logic        i_w_AN0,
    input  logic        i_w_AN1,
    input  logic        i_w_AN2,
    input  logic        i_w_AN3,
    input  logic        i_w_CA,
    input  logic        i_w_CB,
    input  logic        i_w_CC,
    input  logic        i_w_CD,
    input  logic        i_w_CE,
    input  logic        i_w_CF,
    input  logic        i_w_CG,
    input  logic        i_w_DP,
    output logic [15:0] o_r_digits,
    output logic [3:0]  o_r_dp,
    output logic [3:0]  o_r_glyph_err,
    output logic        o_r_frame_valid,
    output logic        o_r_conflict,
    output logic        o_r_stalled
);

    // Idle counter saturates at TIMEOUT_CYCLES-1; the stall is declared on
    // the edge that takes it there.
    localparam logic [15:0] c_IDLE_MAX  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_IDLE_FIRE = 16'(TIMEOUT_CYCLES - 2);

    localparam logic [0:0] c_ST_SCAN    = 1'b0;
    localparam logic [0:0] c_ST_STALLED = 1'b1;

    seg7_bus_t        w_pins;
    seg7_bus_t        w_sample;
    logic             w_capture;
    logic [1:0]       w_digit_idx;
    glyph_t           w_glyph;
    logic             w_publish;
    logic             w_timeout;
    logic [3:0]       w_mask_next;
    logic [0:0]       w_state_next;

    logic [3:0][3:0]  r_shadow_digits;
    logic [3:0]       r_shadow_dp;
    logic [3:0]       r_shadow_err;
    logic [3:0]       r_mask;
    logic [15:0]      r_idle;
    logic [0:0]       r_state;
    logic [15:0]      r_digits;
    logic [3:0]       r_dp;
    logic [3:0]       r_glyph_err;
    logic             r_frame_valid;
    logic             r_conflict;

    assign w_pins = '{
        an_n:  {i_w_AN3, i_w_AN2, i_w_AN1, i_w_AN0},
        seg_n: {i_w_CG, i_w_CF, i_w_CE, i_w_CD, i_w_CC, i_w_CB, i_w_CA},
        dp_n:  i_w_DP
    };

`ifdef SEG7_SCAN_DECODER_SYNC_EN
    seg7_bus_t r_sync_meta;
    seg7_bus_t r_sync_out;

    // Two-flop synchroniser; resets to the idle bus so no phantom digit
    // is seen while it fills.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_sync_meta <= c_BUS_IDLE;
            r_sync_out  <= c_BUS_IDLE;
        end else begin
            r_sync_meta <= w_pins;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_sample = r_sync_out;
`else
    // Driver shares this clock, so the pins are sampled directly.
    assign w_sample = w_pins;
`endif

    seg7_settle_filter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk       (i_w_clk),
        .rst       (i_w_reset),
        .i_sample  (w_sample),
        .o_capture (w_capture)
    );

    // Position of the active anode; only meaningful when a capture fires,
    // which guarantees exactly one anode is low.
    always_comb begin
        w_digit_idx = 2'd0;
        for (int i = 0; i < c_ANODE_COUNT; i++) begin
            if (!w_sample.an_n[i]) begin
                w_digit_idx = 2'(i);
            end
        end
    end

    assign w_glyph   = f_glyph_decode(~w_sample.seg_n);
    assign w_publish = (r_mask == 4'hF);
    assign w_timeout = !w_capture && (r_idle == c_IDLE_FIRE);

    // Capture mask: publishing or a stall empties it first, so a capture in
    // the same cycle lands in the fresh mask.
    always_comb begin
        w_mask_next = r_mask;
        if (w_publish || w_timeout) begin
            w_mask_next = 4'h0;
        end
        if (w_capture) begin
            w_mask_next[w_digit_idx] = 1'b1;
        end
    end

    // Scan/stall state: a stall is left only by a fresh capture.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_SCAN: begin
                if (w_timeout) begin
                    w_state_next = c_ST_STALLED;
                end
            end
            c_ST_STALLED: begin
                if (w_capture) begin
                    w_state_next = c_ST_SCAN;
                end
            end
            default: w_state_next = c_ST_SCAN;
        endcase
    end

    // Shadow registers, mask, idle counter, state and published frame.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_shadow_digits <= '0;
            r_shadow_dp     <= 4'h0;
            r_shadow_err    <= 4'h0;
            r_mask          <= 4'h0;
            r_idle          <= 16'd0;
            r_state         <= c_ST_SCAN;
            r_digits        <= 16'h0000;
            r_dp            <= 4'h0;
            r_glyph_err     <= 4'h0;
            r_frame_valid   <= 1'b0;
            r_conflict      <= 1'b0;
        end else begin
            r_conflict    <= (f_active_anodes(w_sample.an_n) > 3'd1);
            r_frame_valid <= w_publish;
            r_mask        <= w_mask_next;
            r_state       <= w_state_next;

            // Shadows are copied before this edge's capture overwrites them.
            if (w_publish) begin
                r_digits    <= r_shadow_digits;
                r_dp        <= r_shadow_dp;
                r_glyph_err <= r_shadow_err;
            end

            if (w_capture) begin
                r_shadow_digits[w_digit_idx] <= w_glyph.nibble;
                r_shadow_dp[w_digit_idx]     <= ~w_sample.dp_n;
                r_shadow_err[w_digit_idx]    <= w_glyph.err;
            end

            if (w_capture) begin
                r_idle <= 16'd0;
            end else if (r_idle != c_IDLE_MAX) begin
                r_idle <= r_idle + 16'd1;
            end
        end
    end

    assign o_r_digits      = r_digits;
    assign o_r_dp          = r_dp;
    assign o_r_glyph_err   = r_glyph_err;
    assign o_r_frame_valid = r_frame_valid;
    assign o_r_conflict    = r_conflict;
    assign o_r_stalled     = (r_state == c_ST_STALLED);

endmodule : seg7_scan_decoder

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Self-checking bench for seg7_scan_decoder. Directed scans
//                followed by randomized bus traffic; a stream-level reference
//                model feeds a scoreboard of expected frames, and a monitor
//                compares every published frame and the per-cycle flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        i_w_reset = 1'b1;
    logic        i_w_AN0 = 1'b1, i_w_AN1 = 1'b1, i_w_AN2 = 1'b1, i_w_AN3 = 1'b1;
    logic        i_w_CA = 1'b1, i_w_CB = 1'b1, i_w_CC = 1'b1, i_w_CD = 1'b1;
    logic        i_w_CE = 1'b1, i_w_CF = 1'b1, i_w_CG = 1'b1, i_w_DP = 1'b1;
    logic [15:0] o_r_digits;
    logic [3:0]  o_r_dp;
    logic [3:0]  o_r_glyph_err;
    logic        o_r_frame_valid;
    logic        o_r_conflict;
    logic        o_r_stalled;

    // Glyph patterns (active-high gfedcba) for hex 0..F.
    logic [6:0] glyph_rom [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int failures = 0;
    int frames_seen = 0;
    int model_edge = 1;
    int mon_edge = 0;

    frame_t sb[$];
    frame_t last_pub = '0;

    // Reference model state: bus stream as {an_n[3:0], seg_n[6:0], dp_n}.
    logic [11:0] run_vec = 12'hFFF;
    int          run_len = 0;
    logic [3:0]  captured = 4'h0;
    logic [3:0]  sh_digit [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  sh_dp = 4'h0;
    logic [3:0]  sh_err = 4'h0;
    int          idle = 0;
    logic        exp_stalled = 1'b0;
    logic        exp_conflict = 1'b0;
    logic [11:0] dl1 = 12'hFFF;
    logic [11:0] dl2 = 12'hFFF;

    seg7_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_w_clk         (clk),
        .i_w_reset       (i_w_reset),
        .i_w_AN0         (i_w_AN0),
        .i_w_AN1         (i_w_AN1),
        .i_w_AN2         (i_w_AN2),
        .i_w_AN3         (i_w_AN3),
        .i_w_CA          (i_w_CA),
        .i_w_CB          (i_w_CB),
        .i_w_CC          (i_w_CC),
        .i_w_CD          (i_w_CD),
        .i_w_CE          (i_w_CE),
        .i_w_CF          (i_w_CF),
        .i_w_CG          (i_w_CG),
        .i_w_DP          (i_w_DP),
        .o_r_digits      (o_r_digits),
        .o_r_dp          (o_r_dp),
        .o_r_glyph_err   (o_r_glyph_err),
        .o_r_frame_valid (o_r_frame_valid),
        .o_r_conflict    (o_r_conflict),
        .o_r_stalled     (o_r_stalled)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for one clock edge: a digit is taken when the same
    // single-anode bus value has been seen SETTLE samples in a row; four
    // distinct digits make a frame published on the following edge.
    task automatic model_step(input logic r, input logic [11:0] pins);
        logic [11:0] v;
        int          lows;
        int          idx;
        logic [3:0]  nib;
        logic        e;
        frame_t      f;
        if (r) begin
            dl1 = 12'hFFF; dl2 = 12'hFFF; run_vec = 12'hFFF; run_len = 0;
            captured = 4'h0; idle = 0; exp_stalled = 1'b0; exp_conflict = 1'b0;
            sh_dp = 4'h0; sh_err = 4'h0;
            for (int d = 0; d < 4; d++) sh_digit[d] = 4'h0;
            sb.delete();
            last_pub = '0;
            return;
        end
`ifdef SEG7_SCAN_DECODER_SYNC_EN
        v = dl2; dl2 = dl1; dl1 = pins;
`else
        v = pins;
`endif
        if (v == run_vec) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_vec = v;
            run_len = 1;
        end
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[8+i]) begin lows++; idx = i; end
        end
        exp_conflict = (lows >= 2);
        if (run_len == SETTLE && lows == 1) begin
            nib = 4'h0; e = 1'b1;
            for (int g = 0; g < 16; g++) begin
                if ((~v[7:1]) == glyph_rom[g]) begin nib = 4'(g); e = 1'b0; end
            end
            sh_digit[idx] = nib; sh_dp[idx] = ~v[0]; sh_err[idx] = e;
            captured[idx] = 1'b1;
            idle = 0;
            exp_stalled = 1'b0;
            if (captured == 4'hF) begin
                f.cyc = 32'(model_edge + 1);
                for (int d = 0; d < 4; d++) f.digits[4*d +: 4] = sh_digit[d];
                f.dp = sh_dp; f.err = sh_err;
                sb.push_back(f);
                captured = 4'h0;
            end
        end else if (idle < TIMEOUT - 1) begin
            idle++;
            if (idle == TIMEOUT - 1) begin
                exp_stalled = 1'b1;
                captured = 4'h0;
            end
        end
    endtask

    // Drive one cycle of bus (seg and dp given active-high) and model it.
    task automatic drive(input logic r, input logic [3:0] an_n, input logic [6:0] seg, input logic dp);
        @(negedge clk);
        i_w_reset = r;
        {i_w_AN3, i_w_AN2, i_w_AN1, i_w_AN0} = an_n;
        {i_w_CG, i_w_CF, i_w_CE, i_w_CD, i_w_CC, i_w_CB, i_w_CA} = ~seg;
        i_w_DP = ~dp;
        model_edge++;
        model_step(r, {an_n, ~seg, ~dp});
    endtask

    task automatic hold(input logic [3:0] an_n, input logic [6:0] seg, input logic dp, input int n);
        repeat (n) drive(1'b0, an_n, seg, dp);
    endtask

    task automatic show(input int d, input logic [6:0] seg, input logic dp, input int n);
        logic [3:0] an_n;
        an_n = 4'hF;
        an_n[d] = 1'b0;
        hold(an_n, seg, dp, n);
    endtask

    task automatic blank(input int n);
        hold(4'hF, 7'h00, 1'b0, n);
    endtask

    // Monitor: per-cycle flags, scoreboard pop on every frame pulse, and
    // hold-check of published data between pulses.
    initial begin
        frame_t f;
        forever begin
            @(posedge clk);
            #1;
            mon_edge++;
            check_val("conflict", {31'd0, o_r_conflict}, {31'd0, exp_conflict});
            check_val("stalled", {31'd0, o_r_stalled}, {31'd0, exp_stalled});
            if (o_r_frame_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_valid: unexpected pulse digits=%h (t=%0t)", o_r_digits, $time);
                end else begin
                    f = sb.pop_front();
                    frames_seen++;
                    check_val("frame_cycle", 32'(mon_edge), f.cyc);
                    check_val("frame_digits", {16'd0, o_r_digits}, {16'd0, f.digits});
                    check_val("frame_dp", {28'd0, o_r_dp}, {28'd0, f.dp});
                    check_val("frame_err", {28'd0, o_r_glyph_err}, {28'd0, f.err});
                    last_pub = f;
                end
            end else begin
                check_val("held_digits", {16'd0, o_r_digits}, {16'd0, last_pub.digits});
                check_val("held_dp", {28'd0, o_r_dp}, {28'd0, last_pub.dp});
                check_val("held_err", {28'd0, o_r_glyph_err}, {28'd0, last_pub.err});
                if (sb.size() != 0 && int'(sb[0].cyc) < mon_edge) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_missing: no pulse at edge %0d (t=%0t)", sb[0].cyc, $time);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int base;
        int kind;
        logic [3:0] an_n;
        logic [6:0] seg;
        int a;
        int b;

        // Reset state
        drive(1'b1, 4'hF, 7'h00, 1'b0);
        drive(1'b1, 4'hF, 7'h00, 1'b0);
        @(posedge clk); #1;
        check_val("reset_digits", {16'd0, o_r_digits}, 32'd0);
        check_val("reset_valid", {31'd0, o_r_frame_valid}, 32'd0);
        check_val("reset_stalled", {31'd0, o_r_stalled}, 32'd0);
        blank(5);

        // Basic scan 0,1,2,3 with DP on digit 2
        base = frames_seen;
        show(0, 7'h3F, 1'b0, 8); show(1, 7'h06, 1'b0, 8);
        show(2, 7'h5B, 1'b1, 8); show(3, 7'h4F, 1'b0, 8);
        blank(4);
        check_val("scan_frames", 32'(frames_seen - base), 32'd1);
        check_val("scan_digits", {16'd0, o_r_digits}, 32'h3210);
        check_val("scan_dp", {28'd0, o_r_dp}, 32'h4);
        check_val("scan_err", {28'd0, o_r_glyph_err}, 32'h0);

        // Short anode pulse is ignored
        base = frames_seen;
        show(0, 7'h3F, 1'b0, 8); show(1, 7'h06, 1'b0, 8); show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h7F, 1'b0, 2);
        blank(4);
        check_val("pulse_frames", 32'(frames_seen - base), 32'd0);
        show(3, 7'h4F, 1'b0, 8);
        blank(4);
        check_val("pulse_done_frames", 32'(frames_seen - base), 32'd1);
        check_val("pulse_done_digits", {16'd0, o_r_digits}, 32'h3210);

        // Anode conflict
        base = frames_seen;
        show(0, 7'h66, 1'b0, 8); show(1, 7'h6D, 1'b0, 8);
        hold(4'b1100, 7'h3F, 1'b0, 8);
        @(posedge clk); #1;
        check_val("conflict_flag", {31'd0, o_r_conflict}, 32'd1);
        show(2, 7'h7D, 1'b0, 8); show(3, 7'h07, 1'b0, 8);
        blank(4);
        check_val("conflict_frames", 32'(frames_seen - base), 32'd1);
        check_val("conflict_digits", {16'd0, o_r_digits}, 32'h7654);

        // Invalid glyph on digit 3
        show(0, 7'h7F, 1'b0, 8); show(1, 7'h6F, 1'b0, 8);
        show(2, 7'h77, 1'b0, 8); show(3, 7'h55, 1'b0, 8);
        blank(4);
        check_val("badglyph_err", {28'd0, o_r_glyph_err}, 32'h8);
        check_val("badglyph_digits", {16'd0, o_r_digits}, 32'h0A98);

        // Stall after partial frame, then recovery
        base = frames_seen;
        show(0, 7'h39, 1'b0, 8); show(1, 7'h5E, 1'b0, 8);
        blank(70);
        @(posedge clk); #1;
        check_val("stall_flag", {31'd0, o_r_stalled}, 32'd1);
        check_val("stall_retained", {16'd0, o_r_digits}, 32'h0A98);
        show(0, 7'h39, 1'b0, 8); show(1, 7'h5E, 1'b0, 8);
        show(2, 7'h79, 1'b0, 8); show(3, 7'h71, 1'b0, 8);
        blank(4);
        check_val("stall_frames", 32'(frames_seen - base), 32'd1);
        check_val("stall_clear", {31'd0, o_r_stalled}, 32'd0);
        check_val("stall_digits", {16'd0, o_r_digits}, 32'hFEDC);

        // Reset mid-frame
        show(0, 7'h06, 1'b0, 8); show(1, 7'h06, 1'b0, 8); show(2, 7'h06, 1'b0, 8);
        drive(1'b1, 4'hF, 7'h00, 1'b0);
        @(posedge clk); #1;
        check_val("midreset_digits", {16'd0, o_r_digits}, 32'd0);
        check_val("midreset_dp", {28'd0, o_r_dp}, 32'd0);
        base = frames_seen;
        show(3, 7'h06, 1'b1, 8);
        blank(4);
        check_val("midreset_partial", 32'(frames_seen - base), 32'd0);
        show(0, 7'h5B, 1'b0, 8); show(1, 7'h5B, 1'b0, 8); show(2, 7'h5B, 1'b0, 8);
        blank(4);
        check_val("midreset_frames", 32'(frames_seen - base), 32'd1);
        check_val("midreset_newdigits", {16'd0, o_r_digits}, 32'h1222);

        // Randomized traffic
        for (int s = 0; s < 400; s++) begin
            kind = $urandom_range(0, 9);
            seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph_rom[$urandom_range(0, 15)];
            if (kind == 0) begin
                an_n = 4'hF;
            end else if (kind == 1) begin
                a = $urandom_range(0, 3);
                b = (a + 1 + $urandom_range(0, 2)) % 4;
                an_n = 4'hF;
                an_n[a] = 1'b0;
                an_n[b] = 1'b0;
            end else begin
                an_n = 4'hF;
                an_n[$urandom_range(0, 3)] = 1'b0;
            end
            hold(an_n, seg, 1'($urandom), $urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) blank(70);
            if ($urandom_range(0, 99) == 0) drive(1'b1, 4'hF, 7'h00, 1'b0);
        end

        blank(10);
        check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg7_scan_decoder

`default_nettype wire
